sort_stream_bist: RTL

Built-in self-test driver and checker for the byte-stream sorter interface (in_valid/in_data in, out_valid/out_data back). It is the opposite end of the sorter's port pair. It generates one frame of N bytes, either pseudo-random or worst-case descending, and drives it into the sorter. It then collects the returned stream and checks length, non-decreasing order and checksum, so the sorter can be qualified on silicon without the simulation pattern.

---
 rtl/sort_stream_bist.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sort_stream_bist.sv
// Built-in self-test for the byte-stream sorter: sends one N-byte frame,
// then checks the returned stream for length, non-decreasing order and checksum.
module sort_stream_bist #(
    parameter int          N        = 16,
    parameter int          TIMEOUT  = 1024,
    parameter logic [15:0] DEF_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] seed,
    output logic        core_in_valid,
    output logic [7:0]  core_in_data,
    input  logic        core_out_valid,
    input  logic [7:0]  core_out_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    N8     = 8'(N);
    localparam logic [7:0]    N_LAST = 8'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    state_t        state, state_nxt;
    logic          mode_r;
    logic [15:0]   lfsr, seed_eff;
    logic [7:0]    send_idx, rx_cnt, prev;
    logic [15:0]   tx_sum, rx_sum, rx_sum_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    err, err_new;
    logic          accept_start, take, last_rx, tmo_hit;

    // Fibonacci taps 16,14,13,11; shift left, feedback into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign seed_eff     = (seed == 16'd0) ? DEF_SEED : seed;
    assign accept_start = start && (state == S_IDLE || state == S_DONE);
    assign take         = core_out_valid && (state == S_WAIT || state == S_RECV);
    assign last_rx      = take && (rx_cnt == N_LAST);
    assign tmo_hit      = (state == S_WAIT || state == S_RECV) && !core_out_valid
                          && (tmo_cnt == T_LAST);
    assign rx_sum_nxt   = rx_sum + {8'd0, core_out_data};

    always_comb begin
        state_nxt = state;
        err_new   = 3'd0;
        case (state)
            S_IDLE: if (start) state_nxt = S_SEND;
            S_SEND: begin
                if (core_out_valid) err_new = 3'd2;
                if (send_idx == N8) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_out_valid) begin
                    state_nxt = S_RECV;
                end else if (tmo_hit) begin
                    err_new   = 3'd4;
                    state_nxt = S_DONE;
                end
            end
            S_RECV: begin
                if (core_out_valid) begin
                    // order outranks checksum when both hit on the last byte
                    if (core_out_data < prev)
                        err_new = 3'd1;
                    else if (last_rx && rx_sum_nxt != tx_sum)
                        err_new = 3'd3;
                    if (last_rx) state_nxt = S_DONE;
                end else if (tmo_hit) begin
                    err_new   = 3'd4;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start)
                    state_nxt = S_SEND;
                else if (core_out_valid)
                    err_new = 3'd2;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mode_r        <= 1'b0;
            lfsr          <= 16'd0;
            send_idx      <= 8'd0;
            rx_cnt        <= 8'd0;
            prev          <= 8'd0;
            tx_sum        <= 16'd0;
            rx_sum        <= 16'd0;
            tmo_cnt       <= '0;
            err           <= 3'd0;
            core_in_valid <= 1'b0;
            core_in_data  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (err == 3'd0 && err_new != 3'd0) err <= err_new;
            if (core_in_valid) tx_sum <= tx_sum + {8'd0, core_in_data};

            if (take) begin
                rx_cnt  <= rx_cnt + 8'd1;
                rx_sum  <= rx_sum_nxt;
                prev    <= core_out_data;
                tmo_cnt <= '0;
            end else if (state == S_WAIT || state == S_RECV) begin
                tmo_cnt <= tmo_cnt + T_ONE;
            end

            if (accept_start) begin
                // byte 0 goes out on the cycle right after start
                mode_r        <= mode;
                core_in_valid <= 1'b1;
                core_in_data  <= mode ? N_LAST : seed_eff[7:0];
                lfsr          <= lfsr_step(seed_eff);
                send_idx      <= 8'd1;
                tx_sum        <= 16'd0;
                rx_sum        <= 16'd0;
                rx_cnt        <= 8'd0;
                prev          <= 8'd0;
                tmo_cnt       <= '0;
                err           <= 3'd0;
            end else if (state == S_SEND) begin
                if (send_idx == N8) begin
                    core_in_valid <= 1'b0;
                    core_in_data  <= 8'd0;
                end else begin
                    core_in_valid <= 1'b1;
                    core_in_data  <= mode_r ? (N_LAST - send_idx) : lfsr[7:0];
                    lfsr          <= lfsr_step(lfsr);
                    send_idx      <= send_idx + 8'd1;
                end
            end
        end
    end

    assign busy     = (state == S_SEND) || (state == S_WAIT) || (state == S_RECV);
    assign done     = (state == S_DONE);
    assign pass     = done && (err == 3'd0);
    assign err_code = err;

endmodule
